irq_loopback_router: RTL and testbench
======================================

Name: irq_loopback_router

Overview:
- Interrupt crossbar between CPU_NB CPU models.
- Each CPU drives a 32-bit command word on its TX lane. The block decodes it and sets or clears bits in per-CPU 32-bit pending-IRQ registers.
- Pending registers are driven back to the CPUs on the RX lanes.
- Sits at top level between the CPU instances (or their multisim server proxies) and closes the IRQ loop.

Parameters:
- CPU_NB, 4, number of CPUs / lanes; legal range 1..32.
- LATENCY, 1, cycles from command sample to visible o_irq change; legal range 1..8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_irq  input  [CPU_NB] x 32  unpacked array; command word per source CPU s.
- o_irq  output  [CPU_NB] x 32  unpacked array; pending-IRQ register of destination CPU d.

Behaviour:
- Command word fields:
  - [31] valid
  - [30] op (1=set, 0=clear)
  - [29] broadcast
  - [9:5] irq line L (0..31)
  - [4:0] target CPU T
  - all other bits ignored
- Command is ignored when valid=0.
- A command is sampled on every rising edge while valid=1. A held word re-applies each cycle, which is idempotent.
- Unicast (broadcast=0): acts on o_irq[T][L]. Ignored entirely when T >= CPU_NB.
- Broadcast (broadcast=1): T is ignored; acts on o_irq[d][L] for every d != s (sender excluded).
- Pipeline:
  - Sampled commands enter a LATENCY-1 deep register pipeline, then update the pending registers.
  - o_irq is the pending-register output, so total latency = LATENCY edges.
  - LATENCY=1: command present before edge k is visible right after edge k.
- Same-cycle merge, per destination bit:
  - next = (cur | set_mask) & ~(clear_mask & ~set_mask)
  - Set wins over clear when both target the same bit in the same cycle, from any combination of sources.
  - Multiple sets (or multiple clears) to the same bit are equivalent to one.
- Bits untouched by any command hold their value indefinitely. There is no auto-clear.
- Reset:
  - rst=1 at an edge clears all pending registers (o_irq=0 for all lanes) and all pipeline stages.
  - Commands sampled during reset are dropped.
  - Commands already in flight when rst asserts mid-operation are discarded.
  - First command accepted is the one present at the first edge with rst=0.
- No combinational path from i_irq to o_irq.
- o_irq values are fully deterministic; no X propagation after reset.

Test Plan:
- Reset: assert rst for 2 cycles with all lanes driving 0xFFFF_FFFF -> all o_irq == 0 after reset; also 0 one cycle after rst deasserts.
- Unicast set/clear, LATENCY=1: cpu0 drives 0xC000_0062 (set, L=3, T=2) for one cycle -> o_irq[2] == 0x0000_0008 after that edge, other lanes 0. Then cpu1 drives 0x8000_0062 (clear, same L and T) -> o_irq[2] == 0.
- Broadcast: cpu1 drives 0xE000_00A0 (set, broadcast, L=5) -> o_irq[0], o_irq[2], o_irq[3] == 0x20; o_irq[1] == 0.
- Conflict: same cycle, cpu0 sets L=7 on T=3 and cpu2 clears L=7 on T=3 -> o_irq[3][7] == 1. Out-of-range T=9 with CPU_NB=4 -> no change on any lane.
- Latency and reset mid-flight, LATENCY=3: set command at edge k -> o_irq unchanged after edges k and k+1, updated after edge k+2. Repeat with rst asserted at edge k+1 -> o_irq stays 0.
- Hold and idle: valid command held 10 cycles, then valid=0 -> bit remains set. Random valid=0 words with non-zero payload -> no change on any lane.

Source files
------------

// File: rtl/irq_loopback_router.sv
// IRQ crossbar: decodes per-CPU command words into set/clear masks, delays them
// LATENCY-1 stages, and merges them into per-CPU pending-IRQ registers.
module irq_loopback_router #(
    parameter int unsigned CPU_NB  = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_irq [CPU_NB],
    output logic [31:0] o_irq [CPU_NB]
);

    localparam int unsigned DW = 32;
    localparam int unsigned VW = CPU_NB * DW;
    localparam int unsigned PD = LATENCY - 1;

    logic [VW-1:0] set_c;
    logic [VW-1:0] clr_c;
    logic [VW-1:0] set_eff;
    logic [VW-1:0] clr_eff;
    logic          cmd_unused;
    logic          hit;
    logic [DW-1:0] line_mask;

    // Command decode: each destination collects the set and clear lines aimed at it.
    always_comb begin
        set_c      = '0;
        clr_c      = '0;
        cmd_unused = 1'b0;
        hit        = 1'b0;
        line_mask  = '0;
        for (int unsigned s = 0; s < CPU_NB; s++) begin
            cmd_unused = cmd_unused ^ (^i_irq[s][28:10]);
            line_mask  = DW'(1) << i_irq[s][9:5];
            for (int unsigned d = 0; d < CPU_NB; d++) begin
                hit = i_irq[s][31] &&
                      (i_irq[s][29] ? (s != d) : (i_irq[s][4:0] == 5'(d)));
                if (hit) begin
                    if (i_irq[s][30]) begin
                        set_c[d*DW +: DW] = set_c[d*DW +: DW] | line_mask;
                    end else begin
                        clr_c[d*DW +: DW] = clr_c[d*DW +: DW] | line_mask;
                    end
                end
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [VW-1:0] set_pipe_q [PD];
            logic [VW-1:0] clr_pipe_q [PD];

            // Mask delay line; reset flushes every in-flight command.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < PD; i++) begin
                        set_pipe_q[i] <= '0;
                        clr_pipe_q[i] <= '0;
                    end
                end else begin
                    set_pipe_q[0] <= set_c;
                    clr_pipe_q[0] <= clr_c;
                    for (int unsigned i = 1; i < PD; i++) begin
                        set_pipe_q[i] <= set_pipe_q[i-1];
                        clr_pipe_q[i] <= clr_pipe_q[i-1];
                    end
                end
            end

            assign set_eff = set_pipe_q[PD-1];
            assign clr_eff = clr_pipe_q[PD-1];
        end else begin : g_nopipe
            assign set_eff = set_c;
            assign clr_eff = clr_c;
        end
    endgenerate

    logic [DW-1:0] pend_q [CPU_NB];
    logic [DW-1:0] pend_d [CPU_NB];
    logic [DW-1:0] set_w;
    logic [DW-1:0] clr_w;

    // Set wins over clear on the same bit in the same cycle.
    always_comb begin
        set_w = '0;
        clr_w = '0;
        for (int unsigned d = 0; d < CPU_NB; d++) begin
            set_w     = set_eff[d*DW +: DW];
            clr_w     = clr_eff[d*DW +: DW];
            pend_d[d] = (pend_q[d] | set_w) & ~(clr_w & ~set_w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned d = 0; d < CPU_NB; d++) begin
                pend_q[d] <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < CPU_NB; d++) begin
                pend_q[d] <= pend_d[d];
            end
        end
    end

    always_comb begin
        for (int unsigned d = 0; d < CPU_NB; d++) begin
            o_irq[d] = pend_q[d];
        end
    end

endmodule

// File: tb/tb_irq_loopback_router.sv
// Bench for irq_loopback_router: LATENCY=1 and LATENCY=3 instances share stimulus and
// are compared every cycle against a per-bit command model, plus literal checkpoints.
module tb_irq_loopback_router;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd [NB];
    logic [31:0] oa  [NB];
    logic [31:0] ob  [NB];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    irq_loopback_router #(.CPU_NB(NB), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .i_irq(cmd), .o_irq(oa)
    );

    irq_loopback_router #(.CPU_NB(NB), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .i_irq(cmd), .o_irq(ob)
    );

    // Reference: history of sampled words/resets per edge, pending bits per lane.
    logic [31:0] hist_w [8][NB];
    logic        hist_r [8];
    logic [31:0] ma [NB];
    logic [31:0] mb [NB];
    int          n = 8;
    logic        started = 1'b0;
    logic [31:0] w;

    initial begin
        for (int i = 0; i < 8; i++) hist_r[i] = 1'b1;
    end

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %08h expected %08h", nm, idx, act, exp);
        end
    endtask

    // New value of destination d's pending word after applying the commands of one edge.
    function automatic logic [31:0] merge(input logic [31:0] old, input int d, input int slot);
        logic [31:0] r;
        logic [31:0] c;
        bit any_s, any_c, tgt;
        r = old;
        for (int l = 0; l < 32; l++) begin
            any_s = 0;
            any_c = 0;
            for (int s = 0; s < NB; s++) begin
                c = hist_w[slot][s];
                if (c[31]) begin
                    tgt = c[29] ? (s != d) : (int'(c[4:0]) == d);
                    if (tgt && int'(c[9:5]) == l) begin
                        if (c[30]) any_s = 1;
                        else       any_c = 1;
                    end
                end
            end
            if (any_s)      r[l] = 1'b1;
            else if (any_c) r[l] = 1'b0;
        end
        return r;
    endfunction

    // A command sampled lat-1 edges ago lands now only if no reset hit it on the way.
    function automatic bit flows(input int lat);
        for (int i = 0; i < lat; i++) begin
            if (hist_r[(n - i) % 8]) return 0;
        end
        return 1;
    endfunction

    always @(posedge clk) begin
        n++;
        hist_r[n % 8] = rst;
        for (int s = 0; s < NB; s++) hist_w[n % 8][s] = cmd[s];
        if (rst) started = 1'b1;
        for (int d = 0; d < NB; d++) begin
            if (rst)           ma[d] = 32'h0;
            else if (flows(1)) ma[d] = merge(ma[d], d, n % 8);
            if (rst)           mb[d] = 32'h0;
            else if (flows(3)) mb[d] = merge(mb[d], d, (n - 2) % 8);
        end
        #1;
        if (started) begin
            for (int d = 0; d < NB; d++) begin
                check("model_lat1", d, oa[d], ma[d]);
                check("model_lat3", d, ob[d], mb[d]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        for (int s = 0; s < NB; s++) cmd[s] = 32'h0;
    endtask

    task automatic check_lanes(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input bit lat3);
        logic [31:0] e [NB];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int d = 0; d < NB; d++) begin
            if (lat3) check(nm, d, ob[d], e[d]);
            else      check(nm, d, oa[d], e[d]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < NB; s++) cmd[s] = 32'hFFFF_FFFF;
        cyc(); cyc();
        check_lanes("reset_a", 0, 0, 0, 0, 0);
        check_lanes("reset_b", 0, 0, 0, 0, 1);
        rst = 1'b0;
        idle();
        cyc();
        check_lanes("post_reset_a", 0, 0, 0, 0, 0);
        check_lanes("post_reset_b", 0, 0, 0, 0, 1);

        // Unicast set L=3 on T=2, then clear from another CPU.
        cmd[0] = 32'hC000_0062;
        cyc();
        idle();
        check_lanes("uni_set_a", 0, 0, 32'h8, 0, 0);
        check("lat3_edge_k", 2, ob[2], 32'h0);
        cyc();
        check("lat3_edge_k1", 2, ob[2], 32'h0);
        cyc();
        check("lat3_edge_k2", 2, ob[2], 32'h8);
        cmd[1] = 32'h8000_0062;
        cyc();
        idle();
        check("uni_clr_a", 2, oa[2], 32'h0);
        check("uni_clr_b_pending", 2, ob[2], 32'h8);
        cyc(); cyc();
        check("uni_clr_b", 2, ob[2], 32'h0);

        // Broadcast set L=5 from CPU1.
        cmd[1] = 32'hE000_00A0;
        cyc();
        idle();
        check_lanes("bcast_a", 32'h20, 0, 32'h20, 32'h20, 0);
        cyc(); cyc();
        check_lanes("bcast_b", 32'h20, 0, 32'h20, 32'h20, 1);

        // Set and clear of the same bit in one cycle: set wins.
        cmd[0] = 32'hC000_00E3;
        cmd[2] = 32'h8000_00E3;
        cyc();
        idle();
        check("conflict_a", 3, oa[3], 32'hA0);
        cyc(); cyc();
        check("conflict_b", 3, ob[3], 32'hA0);

        // Out-of-range target.
        cmd[0] = 32'hC000_0009;
        cyc();
        idle();
        cyc(); cyc();
        check_lanes("oor_a", 32'h20, 0, 32'h20, 32'hA0, 0);
        check_lanes("oor_b", 32'h20, 0, 32'h20, 32'hA0, 1);

        // Reset lands while a LATENCY=3 command is in flight.
        cmd[0] = 32'hC000_0021;
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        check_lanes("midflight_b", 0, 0, 0, 0, 1);
        check_lanes("midflight_a", 0, 0, 0, 0, 0);
        cyc();
        check("midflight_b_late", 1, ob[1], 32'h0);

        // Held command, then invalid words with junk payload.
        cmd[3] = 32'hC000_0040;
        repeat (10) cyc();
        idle();
        cyc(); cyc(); cyc();
        check_lanes("hold_a", 32'h4, 0, 0, 0, 0);
        check_lanes("hold_b", 32'h4, 0, 0, 0, 1);
        repeat (20) begin
            for (int s = 0; s < NB; s++) cmd[s] = $urandom() & 32'h7FFF_FFFF;
            cyc();
        end
        idle();
        cyc(); cyc(); cyc();
        check_lanes("invalid_a", 32'h4, 0, 0, 0, 0);
        check_lanes("invalid_b", 32'h4, 0, 0, 0, 1);

        // Random traffic with occasional resets; checked by the model every cycle.
        repeat (3000) begin
            for (int s = 0; s < NB; s++) begin
                w      = $urandom();
                w[31]  = ($urandom_range(0, 9) < 6);
                w[29]  = ($urandom_range(0, 5) == 0);
                w[9:5] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'($urandom_range(0, 7));
                w[4:0] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'($urandom_range(0, 4));
                cmd[s] = w;
            end
            rst = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
